// File: rtl/rom_bank_ctrl.sv
// Eight-slot CPC upper-ROM bank controller: ROM-select latch, read decode, EEPROM write sequencing.
// Optional STATUS_READ_EN macro adds an I/O status read port (d_out/d_oe).
module rom_bank_ctrl #(
  parameter int unsigned BASE_ROM       = 0,
  parameter int unsigned WE_PULSE_CYC   = 2,
  parameter int unsigned WR_HOLDOFF_CYC = 40000
) (
  input  logic       CLK,
  input  logic       RESET_B,
  input  logic       IOREQ_B,
  input  logic       MREQ_B,
  input  logic       WR_B,
  input  logic       RD_B,
  input  logic       ROMEN_B,
  input  logic       A15,
  input  logic       A14,
  input  logic       A13,
  input  logic [7:0] D,
  input  logic [7:0] slot_en,
  input  logic [7:0] wr_en,
  output logic [7:0] romcs_b,
  output logic       romoe_b,
  output logic       romwe_b,
  output logic       romdis,
`ifdef STATUS_READ_EN
  output logic       busy,
  output logic [7:0] d_out,
  output logic       d_oe
`else
  output logic       busy
`endif
);

  localparam int unsigned CNT_W = $clog2(WR_HOLDOFF_CYC + 1);
  localparam logic [4:0]       BASE_BLK   = 5'(BASE_ROM >> 3);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(WE_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(WR_HOLDOFF_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // Bus sample registers (one CLK of latency on every Z80 strobe/address/data)
  logic       ioreq_q, mreq_q, wr_q;
  logic       a15_q, a14_q, a13_q;
  logic [7:0] d_q;

  logic       iowr_prev_q, memwr_prev_q;
  logic [7:0] rom_num_q;
  logic       valid_q;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       wr_sel_q, wr_sel_d;

  logic       iowr_c, iowr_rise_c;
  logic       memwr_c, memwr_rise_c;
  logic       hit_c, rd_act_c, pulse_c;
  logic [2:0] sel_c;

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      ioreq_q <= 1'b1;
      mreq_q  <= 1'b1;
      wr_q    <= 1'b1;
      a15_q   <= 1'b0;
      a14_q   <= 1'b0;
      a13_q   <= 1'b1;
      d_q     <= 8'h00;
    end else begin
      ioreq_q <= IOREQ_B;
      mreq_q  <= MREQ_B;
      wr_q    <= WR_B;
      a15_q   <= A15;
      a14_q   <= A14;
      a13_q   <= A13;
      d_q     <= D;
    end
  end

  assign iowr_c      = !ioreq_q && !wr_q && !a13_q;
  assign iowr_rise_c = iowr_c && !iowr_prev_q;

  // ROM-select latch: one capture per OUT, however long the strobe is held
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      iowr_prev_q <= 1'b0;
      rom_num_q   <= 8'h00;
      valid_q     <= 1'b0;
    end else begin
      iowr_prev_q <= iowr_c;
      if (iowr_rise_c) begin
        rom_num_q <= d_q;
        valid_q   <= 1'b1;
      end
    end
  end

  // slot_en is a static DIP input, so it is used live to drop hit immediately
  assign sel_c        = rom_num_q[2:0];
  assign hit_c        = valid_q && (rom_num_q[7:3] == BASE_BLK) && slot_en[sel_c];
  assign memwr_c      = !mreq_q && !wr_q && a15_q && a14_q && hit_c && wr_en[sel_c];
  assign memwr_rise_c = memwr_c && !memwr_prev_q;
  assign rd_act_c     = hit_c && !ROMEN_B && A14;
  assign pulse_c      = (state_q == ST_PULSE);

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      memwr_prev_q <= 1'b0;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      wr_sel_q     <= 3'd0;
    end else begin
      memwr_prev_q <= memwr_c;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_sel_q     <= wr_sel_d;
    end
  end

  // Write sequencer; write rises outside IDLE are dropped, not queued
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_sel_d = wr_sel_q;
    unique case (state_q)
      ST_IDLE: begin
        if (memwr_rise_c) begin
          wr_sel_d = sel_c;
          cnt_d    = PULSE_LOAD;
          state_d  = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          cnt_d   = HOLD_LOAD;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Chip-select/strobe decode; the write pulse owns the ROM bus while active
  always_comb begin
    romcs_b = 8'hFF;
    romoe_b = ROMEN_B;
    romwe_b = 1'b1;
    romdis  = rd_act_c;
    busy    = (state_q != ST_IDLE);
    if (pulse_c) begin
      romcs_b[wr_sel_q] = 1'b0;
      romoe_b           = 1'b1;
      romwe_b           = 1'b0;
    end else if (rd_act_c) begin
      romcs_b[sel_c] = 1'b0;
    end
  end

`ifdef STATUS_READ_EN
  logic rd_q;

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      rd_q <= 1'b1;
    end else begin
      rd_q <= RD_B;
    end
  end

  assign d_oe  = !ioreq_q && !rd_q && !a13_q;
  assign d_out = {busy, hit_c, 3'b000, sel_c};
`else
  logic unused_rd;
  assign unused_rd = RD_B;
`endif

endmodule

// File: tb/tb_rom_bank_ctrl.sv
// Randomized scoreboard bench for rom_bank_ctrl; expected outputs come from a cycle-indexed
// behavioural model (write windows as cycle ranges), checked by a separate negedge monitor.
module tb_rom_bank_ctrl;

  localparam int BASE = 0;
  localparam int WE   = 2;
  localparam int HOLD = 40000;

  logic       CLK, RESET_B;
  logic       IOREQ_B, MREQ_B, WR_B, RD_B, ROMEN_B, A15, A14, A13;
  logic [7:0] D, slot_en, wr_en;
  logic [7:0] romcs_b;
  logic       romoe_b, romwe_b, romdis, busy;
`ifdef STATUS_READ_EN
  logic [7:0] d_out;
  logic       d_oe;
`endif

  rom_bank_ctrl #(.BASE_ROM(BASE), .WE_PULSE_CYC(WE), .WR_HOLDOFF_CYC(HOLD)) dut (
    .CLK(CLK), .RESET_B(RESET_B), .IOREQ_B(IOREQ_B), .MREQ_B(MREQ_B), .WR_B(WR_B),
    .RD_B(RD_B), .ROMEN_B(ROMEN_B), .A15(A15), .A14(A14), .A13(A13), .D(D),
    .slot_en(slot_en), .wr_en(wr_en), .romcs_b(romcs_b), .romoe_b(romoe_b),
    .romwe_b(romwe_b), .romdis(romdis),
`ifdef STATUS_READ_EN
    .busy(busy), .d_out(d_out), .d_oe(d_oe)
`else
    .busy(busy)
`endif
  );

  typedef struct {
    int         cyc;
    string      name;
    logic [7:0] cs;
    logic       oe, we, dis, bsy, doe;
    logic [7:0] dout;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int we_low = 0;

  // Reference model state: selected ROM and the write windows as cycle ranges
  int m_num = 0;
  bit m_valid = 0;
  int m_ps = -1000000, m_we_end = -1000000, m_pe = -1000000;
  int m_wsel = 0;
  int m_we_exp = 0;
  bit m_doe = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded time limit at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // Monitor: pops the expectation scheduled for the current cycle and compares
  always @(negedge CLK) begin
    exp_t e;
    bit ok;
    if (romwe_b === 1'b0) we_low++;
    if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      total++;
      ok = (e.cyc == cyc) && (romcs_b === e.cs) && (romoe_b === e.oe) &&
           (romwe_b === e.we) && (romdis === e.dis) && (busy === e.bsy);
`ifdef STATUS_READ_EN
      ok = ok && (d_oe === e.doe) && (d_out === e.dout);
`endif
      if (!ok) begin
        bad++;
        $display("FAIL %s cyc=%0d/%0d got cs=%h oe=%b we=%b dis=%b busy=%b want cs=%h oe=%b we=%b dis=%b busy=%b",
                 e.name, cyc, e.cyc, romcs_b, romoe_b, romwe_b, romdis, busy,
                 e.cs, e.oe, e.we, e.dis, e.bsy);
`ifdef STATUS_READ_EN
        $display("  %s status got d_oe=%b d_out=%h want d_oe=%b d_out=%h",
                 e.name, d_oe, d_out, e.doe, e.dout);
`endif
      end
    end
  end

  function automatic bit model_hit();
    logic [7:0] se;
    se = slot_en;
    return m_valid && ((m_num / 8) == (BASE / 8)) && (se[m_num % 8] == 1'b1);
  endfunction

  task automatic push(input string name);
    exp_t e;
    bit pulse, bsy, hit, rd;
    pulse = (cyc >= m_ps) && (cyc < m_we_end);
    bsy   = (cyc >= m_ps) && (cyc < m_pe);
    hit   = model_hit();
    rd    = hit && (ROMEN_B == 1'b0) && (A14 == 1'b1);
    e.cyc  = cyc;
    e.name = name;
    e.cs   = 8'hFF;
    if (pulse)   e.cs[m_wsel] = 1'b0;
    else if (rd) e.cs[m_num % 8] = 1'b0;
    e.oe   = pulse ? 1'b1 : ROMEN_B;
    e.we   = !pulse;
    e.dis  = rd;
    e.bsy  = bsy;
    e.doe  = m_doe;
    e.dout = {bsy, hit, 3'b000, 3'(m_num % 8)};
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic bus_idle();
    IOREQ_B = 1'b1; MREQ_B = 1'b1; WR_B = 1'b1; RD_B = 1'b1; ROMEN_B = 1'b1;
    A15 = 1'b0; A14 = 1'b0; A13 = 1'b1;
  endtask

  task automatic out_sel(input logic [7:0] v);
    IOREQ_B = 1'b0; WR_B = 1'b0; A13 = 1'b0; D = v;
    tick(2);
    m_num = int'(v);
    m_valid = 1'b1;
    bus_idle();
    tick(2);
  endtask

  task automatic rd_check(input string name, input logic romen, input logic a14);
    ROMEN_B = romen; A14 = a14;
    push(name);
    tick();
    bus_idle();
  endtask

  task automatic mem_write(input string name);
    int c;
    logic [7:0] we_bits;
    c = cyc;
    we_bits = wr_en;
    MREQ_B = 1'b0; WR_B = 1'b0; A15 = 1'b1; A14 = 1'b1; ROMEN_B = 1'b1;
    if (model_hit() && we_bits[m_num % 8] && (c + 1 >= m_pe)) begin
      m_ps = c + 2;
      m_we_end = c + 2 + WE;
      m_pe = c + 2 + WE + HOLD;
      m_wsel = m_num % 8;
      m_we_exp += WE;
    end
    push({name, "_a"});
    tick();
    push({name, "_b"});
    tick();
    bus_idle();
  endtask

  task automatic do_reset();
    RESET_B = 1'b0;
    if (cyc < m_we_end) m_we_exp -= (m_we_end - ((cyc > m_ps) ? cyc : m_ps));
    if (cyc < m_we_end) m_we_end = cyc;
    if (cyc < m_pe) m_pe = cyc;
    m_valid = 1'b0;
    m_num = 0;
    m_doe = 1'b0;
  endtask

  initial begin
    RESET_B = 1'b0;
    D = 8'h00; slot_en = 8'h00; wr_en = 8'h00;
    bus_idle();
    tick(2);
    ROMEN_B = 1'b0; A14 = 1'b1;
    push("in_reset");
    tick();
    RESET_B = 1'b1;
    tick();
    rd_check("reset_upper", 1'b0, 1'b1);

    slot_en = 8'hFF;
    out_sel(8'd5);
    rd_check("sel5_upper", 1'b0, 1'b1);
    rd_check("sel5_lower", 1'b0, 1'b0);
    rd_check("sel5_noromen", 1'b1, 1'b1);
    out_sel(8'd9);
    rd_check("sel9_outside", 1'b0, 1'b1);
    slot_en = 8'hF7;
    out_sel(8'd3);
    rd_check("sel3_disabled", 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      slot_en = 8'($urandom);
      out_sel($urandom_range(0, 1) ? 8'($urandom_range(0, 15)) : 8'($urandom));
      for (int j = 0; j < 3; j++)
        rd_check("rand_rd", 1'($urandom), 1'($urandom));
      slot_en = 8'($urandom);
      rd_check("rand_slotflip", 1'b0, 1'b1);
    end

    // Full write cycle on slot 2 with a dropped second write during holdoff
    slot_en = 8'hFF; wr_en = 8'h04;
    out_sel(8'd2);
    mem_write("w1_req");
    push("w1_pulse1");
    tick();
    push("w1_pulse2");
    tick();
    push("w1_hold");
    tick(95);
    rd_check("w1_hold_read", 1'b0, 1'b1);
    mem_write("w1_dropped");
    push("w1_after_drop");
    tick();
`ifdef STATUS_READ_EN
    IOREQ_B = 1'b0; RD_B = 1'b0; A13 = 1'b0;
    push("st_pre");
    tick();
    m_doe = 1'b1;
    push("st_read");
    tick();
    bus_idle();
    push("st_hold");
    tick();
    m_doe = 1'b0;
    push("st_release");
    tick();
`endif
    while (cyc < m_pe - 1) tick();
    push("w1_busy_last");
    tick();
    push("w1_busy_done");
    tick(2);

    // Select OUT during the pulse retargets reads but not the pulse
    mem_write("w2_req");
    IOREQ_B = 1'b0; WR_B = 1'b0; A13 = 1'b0; D = 8'd6;
    push("w2_pulse1");
    tick();
    push("w2_pulse2");
    tick();
    m_num = 6;
    bus_idle();
    rd_check("w2_hold_sel6", 1'b0, 1'b1);
    do_reset();
    push("w2_reset_hold");
    tick();
    RESET_B = 1'b1;
    tick(2);

    // Reset asserted mid-pulse drops the strobe at once
    slot_en = 8'hFF; wr_en = 8'h04;
    out_sel(8'd2);
    mem_write("w3_req");
    push("w3_pulse1");
    tick();
    do_reset();
    ROMEN_B = 1'b0; A14 = 1'b1;
    push("w3_reset_pulse");
    tick();
    RESET_B = 1'b1;
    bus_idle();
    tick(2);
    rd_check("post_reset_read", 1'b0, 1'b1);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    total++;
    if (we_low != m_we_exp) begin
      bad++;
      $display("FAIL we_low_cycles: got %0d want %0d", we_low, m_we_exp);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
